// File: rtl/prga.sv
// rtl/prga.sv - ARC4 pseudo-random generation stage (keystream XOR of a length-prefixed message)
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   en, rdy             start request / idle handshake (en sampled only while rdy=1)
//   s_addr, s_rddata,
//   s_wrdata, s_wren    S memory port (synchronous read, 1-cycle latency)
//   ct_addr, ct_rddata  ciphertext memory read port (ct[0] = length)
//   pt_addr, pt_wrdata,
//   pt_wren             plaintext memory write port (pt[0] = length)

module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WAIT_LEN,
    GET_LEN,
    RD_SI,
    WAIT_SI,
    GET_SI,
    WAIT_SJ,
    GET_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    WAIT_PAD,
    WR_PT
  } state_t;

  state_t     state_q, state_d;
  logic       rdy_q, rdy_d;
  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_wrdata_q, s_wrdata_d;
  logic       s_wren_q, s_wren_d;
  logic [7:0] ct_addr_q, ct_addr_d;
  logic [7:0] pt_addr_q, pt_addr_d;
  logic [7:0] pt_wrdata_q, pt_wrdata_d;
  logic       pt_wren_q, pt_wren_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;

  // Every output is registered: the values a state drives are loaded on the
  // edge that enters that state, so the memories see a stable address for the
  // whole state and its following wait state. Read data valid during a wait
  // state is therefore captured on the edge into the following GET state.
  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = RD_LEN;
          rdy_d     = 1'b0;
          ct_addr_d = 8'd0;
        end
      end
      RD_LEN: begin
        state_d = WAIT_LEN;
      end
      WAIT_LEN: begin
        state_d     = GET_LEN;
        len_d       = ct_rddata;
        pt_addr_d   = 8'd0;
        pt_wrdata_d = ct_rddata;
        pt_wren_d   = 1'b1;
        i_d         = 8'd0;
        j_d         = 8'd0;
        k_d         = 8'd1;
      end
      GET_LEN: begin
        if (len_q == 8'd0) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          state_d  = RD_SI;
          i_d      = i_q + 8'd1;
          s_addr_d = i_q + 8'd1;
        end
      end
      RD_SI: begin
        state_d = WAIT_SI;
      end
      WAIT_SI: begin
        state_d  = GET_SI;
        si_d     = s_rddata;
        j_d      = j_q + s_rddata;
        s_addr_d = j_q + s_rddata;
      end
      GET_SI: begin
        state_d = WAIT_SJ;
      end
      WAIT_SJ: begin
        state_d = GET_SJ;
        sj_d    = s_rddata;
      end
      GET_SJ: begin
        state_d    = WR_SI;
        s_addr_d   = i_q;
        s_wrdata_d = sj_q;
        s_wren_d   = 1'b1;
      end
      WR_SI: begin
        state_d    = WR_SJ;
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
      end
      WR_SJ: begin
        // Pre-swap si/sj give the same sum as the swapped entries.
        state_d   = RD_PAD;
        s_addr_d  = si_q + sj_q;
        ct_addr_d = k_q;
      end
      RD_PAD: begin
        state_d = WAIT_PAD;
      end
      WAIT_PAD: begin
        state_d     = WR_PT;
        pt_addr_d   = k_q;
        pt_wrdata_d = s_rddata ^ ct_rddata;
        pt_wren_d   = 1'b1;
      end
      WR_PT: begin
        // Compare before incrementing so L=255 never needs k to wrap.
        if (k_q == len_q) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          state_d  = RD_SI;
          k_d      = k_q + 8'd1;
          i_d      = i_q + 8'd1;
          s_addr_d = i_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
      pt_wrdata_q <= 8'd0;
      pt_wren_q   <= 1'b0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      len_q       <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_prga.sv
// tb/tb_prga.sv - self-checking bench for prga against a software ARC4 model

module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  always #5 clk = ~clk;

  prga dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];

  logic       ld_we;
  logic [1:0] ld_sel;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  int s_wr_cnt  = 0;
  int pt_wr_cnt = 0;

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (ld_we) begin
      case (ld_sel)
        2'd0:    s_mem[ld_addr]  <= ld_data;
        2'd1:    ct_mem[ld_addr] <= ld_data;
        default: pt_mem[ld_addr] <= ld_data;
      endcase
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_wr_cnt      <= s_wr_cnt + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        pt_wr_cnt       <= pt_wr_cnt + 1;
      end
    end
  end

  logic [7:0] ref_s  [256];
  logic [7:0] ref_ct [256];
  logic [7:0] exp_pt [256];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input logic [1:0] sel);
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_sel  = sel;
      ld_addr = a[7:0];
      ld_data = (sel == 2'd0) ? ref_s[a] : (sel == 2'd1) ? ref_ct[a] : 8'hEE;
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) ref_s[a] = a[7:0];
  endtask

  task automatic ksa(input logic [23:0] key);
    logic [7:0] kb [3];
    logic [7:0] j;
    logic [7:0] t;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    set_identity();
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + ref_s[a] + kb[a % 3];
      t = ref_s[a];
      ref_s[a] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  // Textbook ARC4 PRGA on ref_s; leaves ref_s as the expected final S.
  task automatic model(input int len);
    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] idx;
    i = 8'd0;
    j = 8'd0;
    exp_pt[0] = len[7:0];
    for (int k = 1; k <= len; k++) begin
      i = i + 8'd1;
      j = j + ref_s[i];
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
      idx = ref_s[i] + ref_s[j];
      exp_pt[k] = ref_ct[k] ^ ref_s[idx];
    end
  endtask

  task automatic random_ct(input int len);
    for (int a = 0; a < 256; a++) ref_ct[a] = 8'($urandom_range(0, 255));
    ref_ct[0] = len[7:0];
  endtask

  // Pulses en, then counts cycles with rdy low; optionally re-pulses en mid-run.
  task automatic run(input int extra_en, output int cyc);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    while (rdy == 1'b0 && cyc < 5000) begin
      cyc++;
      en = (cyc == extra_en);
      @(negedge clk);
    end
    en = 1'b0;
    check("run_terminates", {31'd0, rdy}, 32'd1);
  endtask

  task automatic check_result(input string tag, input int len);
    int mism;
    for (int k = 0; k <= len; k++)
      check($sformatf("%s_pt%0d", tag, k), {24'd0, pt_mem[k]}, {24'd0, exp_pt[k]});
    if (len < 255)
      check($sformatf("%s_pt_untouched", tag), {24'd0, pt_mem[len + 1]}, 32'hEE);
    mism = 0;
    for (int a = 0; a < 256; a++)
      if (s_mem[a] !== ref_s[a]) mism++;
    check($sformatf("%s_s_mismatches", tag), mism, 0);
  endtask

  int cyc;
  int sw0;
  int pw0;
  int lo;
  int len;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    ld_we   = 1'b0;
    ld_sel  = 2'd0;
    ld_addr = 8'd0;
    ld_data = 8'd0;

    repeat (2) @(negedge clk);
    check("reset_rdy", {31'd0, rdy}, 32'd1);
    check("reset_s_wren", {31'd0, s_wren}, 32'd0);
    check("reset_pt_wren", {31'd0, pt_wren}, 32'd0);
    check("reset_s_addr", {24'd0, s_addr}, 32'd0);
    check("reset_ct_addr", {24'd0, ct_addr}, 32'd0);
    check("reset_pt_addr", {24'd0, pt_addr}, 32'd0);
    check("reset_s_wrdata", {24'd0, s_wrdata}, 32'd0);
    check("reset_pt_wrdata", {24'd0, pt_wrdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // One byte, identity S: i==j swap, pad 0x02.
    set_identity();
    for (int a = 0; a < 256; a++) ref_ct[a] = 8'h00;
    ref_ct[0] = 8'h01;
    ref_ct[1] = 8'hA5;
    load_mem(2'd0);
    load_mem(2'd1);
    load_mem(2'd2);
    model(1);
    sw0 = s_wr_cnt;
    run(0, cyc);
    check("t1_cycles", cyc, 13);
    check("t1_pt0", {24'd0, pt_mem[0]}, 32'h01);
    check("t1_pt1", {24'd0, pt_mem[1]}, 32'hA7);
    check("t1_s_writes", s_wr_cnt - sw0, 2);
    check_result("t1", 1);

    // Two bytes, identity S: second byte swaps S[2]/S[3].
    set_identity();
    for (int a = 0; a < 256; a++) ref_ct[a] = 8'h00;
    ref_ct[0] = 8'h02;
    load_mem(2'd0);
    load_mem(2'd1);
    load_mem(2'd2);
    model(2);
    run(0, cyc);
    check("t2_cycles", cyc, 23);
    check("t2_pt0", {24'd0, pt_mem[0]}, 32'h02);
    check("t2_pt1", {24'd0, pt_mem[1]}, 32'h02);
    check("t2_pt2", {24'd0, pt_mem[2]}, 32'h05);
    check("t2_s2", {24'd0, s_mem[2]}, 32'h03);
    check("t2_s3", {24'd0, s_mem[3]}, 32'h02);
    check_result("t2", 2);

    // Zero-length message.
    ref_ct[0] = 8'h00;
    load_mem(2'd1);
    load_mem(2'd2);
    model(0);
    sw0 = s_wr_cnt;
    pw0 = pt_wr_cnt;
    run(0, cyc);
    check("t3_cycles", cyc, 3);
    check("t3_s_writes", s_wr_cnt - sw0, 0);
    check("t3_pt_writes", pt_wr_cnt - pw0, 1);
    check_result("t3", 0);

    // KSA-derived S, maximum length.
    ksa(24'h00033C);
    random_ct(255);
    load_mem(2'd0);
    load_mem(2'd1);
    load_mem(2'd2);
    model(255);
    pw0 = pt_wr_cnt;
    run(0, cyc);
    check("t4_cycles", cyc, 2553);
    check("t4_pt_writes", pt_wr_cnt - pw0, 256);
    check_result("t4", 255);

    // Random length continuing from the current S, with en re-pulsed mid-run.
    len = $urandom_range(1, 40);
    random_ct(len);
    load_mem(2'd1);
    load_mem(2'd2);
    model(len);
    pw0 = pt_wr_cnt;
    run(5, cyc);
    check("t5_cycles", cyc, 3 + 10 * len);
    lo = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy !== 1'b1) lo++;
    end
    check("t5_no_restart", lo, 0);
    check("t5_pt_writes", pt_wr_cnt - pw0, len + 1);
    check_result("t5", len);

    // Reset mid-operation, then a fresh run.
    random_ct(10);
    load_mem(2'd1);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int c = 1; c < 40; c++) begin
      en = (c == 5);
      @(negedge clk);
    end
    en = 1'b0;
    check("t6_busy_before_reset", {31'd0, rdy}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_rdy", {31'd0, rdy}, 32'd1);
    check("t6_reset_s_wren", {31'd0, s_wren}, 32'd0);
    check("t6_reset_pt_wren", {31'd0, pt_wren}, 32'd0);
    sw0 = s_wr_cnt;
    pw0 = pt_wr_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lo = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdy !== 1'b1) lo++;
    end
    check("t6_idle_after_reset", lo, 0);
    check("t6_no_writes", (s_wr_cnt - sw0) + (pt_wr_cnt - pw0), 0);

    set_identity();
    for (int a = 0; a < 256; a++) ref_ct[a] = 8'h00;
    ref_ct[0] = 8'h01;
    ref_ct[1] = 8'h5A;
    load_mem(2'd0);
    load_mem(2'd1);
    load_mem(2'd2);
    model(1);
    run(0, cyc);
    check("t6_cycles", cyc, 13);
    check("t6_pt1", {24'd0, pt_mem[1]}, 32'h58);
    check_result("t6", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
